// File: rtl/polymult_pkg.sv
// Shared constants and types for the polynomial-multiplier result path.
// Holds the operand/accumulator widths, result buffer geometry, the
// partial-product beat type and the accumulator FSM state encoding.
package polymult_pkg;

    localparam int DATA_WIDTH   = 64;
    localparam int LANES        = 8;
    localparam int POLY_A_WIDTH = 64;
    localparam int POLY_B_WIDTH = 64;
    localparam int GUARD_BITS   = 8;
    localparam int RESULT_LEN   = POLY_A_WIDTH + POLY_B_WIDTH - 1;
    localparam int IDX_W        = $clog2(RESULT_LEN);
    localparam int ACC_W        = 2 * DATA_WIDTH + GUARD_BITS;

    typedef logic [2*DATA_WIDTH-1:0] prod_t;
    typedef logic [ACC_W-1:0]        acc_t;
    typedef prod_t [LANES-1:0]       beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } acc_state_e;

endpackage

// File: rtl/polymult_acc_lane_add.sv
// Combinational per-lane front end of the result accumulator.
// Computes the target result index for one lane of a beat, decides whether
// the lane lands inside the result buffer, flags a non-zero lane that falls
// outside it, and zero-extends the product to accumulator width.
//   base  : result index of lane 0 for the current beat
//   coeff : this lane's 2*DATA_WIDTH partial product
//   idx   : buffer index for this lane (meaningful only when en=1)
//   en    : lane lands inside the buffer
//   drop  : lane is outside the buffer and carries a non-zero value
//   ext   : coeff zero-extended to ACC_W
module polymult_acc_lane_add
    import polymult_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic [IDX_W-1:0] base,
    input  prod_t            coeff,
    output logic [IDX_W-1:0] idx,
    output logic             en,
    output logic             drop,
    output acc_t             ext
);

    // One extra bit so base+LANE past the top of the buffer cannot wrap
    // back into a valid index.
    logic [IDX_W:0] full_idx;
    logic           in_range;

    assign full_idx = {1'b0, base} + (IDX_W+1)'(LANE);
    assign in_range = (full_idx < (IDX_W+1)'(RESULT_LEN));

    assign idx  = full_idx[IDX_W-1:0];
    assign en   = in_range;
    assign drop = !in_range && (|coeff);
    assign ext  = {{GUARD_BITS{1'b0}}, coeff};

endmodule

// File: rtl/polymult_result_accumulator.sv
// Result accumulator for the polynomial multiplier.
// Accumulates LANES-wide partial-product beats into a RESULT_LEN entry
// coefficient buffer, then drains the finished polynomial one coefficient
// per cycle over a valid/ready stream.
//   clk, rst            : clock, asynchronous active-low reset
//   start               : begin a new product (honoured only when idle)
//   in_valid/in_ready   : beat handshake from the multiplier
//   in_base, in_coeffs  : base result index and LANES partial products
//   in_last             : final beat of the product
//   out_valid/out_ready : coefficient stream handshake
//   out_index, out_coeff: drained coefficient and its index
//   out_last            : marks index RESULT_LEN-1
//   busy                : not idle
//   range_err           : sticky; a non-zero lane fell beyond the buffer
module polymult_result_accumulator
    import polymult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_base,
    input  beat_t            in_coeffs,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output acc_t             out_coeff,
    output logic             out_last,
    output logic             busy,
    output logic             range_err
);

    acc_state_e       state_reg;
    acc_t             acc_reg [RESULT_LEN];
    logic [IDX_W-1:0] cnt_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic             busy_reg;
    logic             range_err_reg;

    logic [IDX_W-1:0] lane_idx [LANES];
    acc_t             lane_ext [LANES];
    logic [LANES-1:0] lane_en;
    logic [LANES-1:0] lane_drop;

    logic beat_fire;
    logic drain_fire;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            polymult_acc_lane_add #(
                .LANE(gi)
            ) u_lane (
                .base (in_base),
                .coeff(in_coeffs[gi]),
                .idx  (lane_idx[gi]),
                .en   (lane_en[gi]),
                .drop (lane_drop[gi]),
                .ext  (lane_ext[gi])
            );
        end
    endgenerate

    // in_ready_reg is high exactly in ACCUM, out_valid_reg exactly in DRAIN.
    assign beat_fire  = in_valid && in_ready_reg;
    assign drain_fire = out_valid_reg && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            range_err_reg <= 1'b0;
            for (int i = 0; i < RESULT_LEN; i++) begin
                acc_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < RESULT_LEN; i++) begin
                            acc_reg[i] <= '0;
                        end
                        range_err_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (beat_fire) begin
                        // Lanes of one beat always target distinct indices,
                        // so these writes never collide.
                        for (int k = 0; k < LANES; k++) begin
                            if (lane_en[k]) begin
                                acc_reg[lane_idx[k]] <= acc_reg[lane_idx[k]] + lane_ext[k];
                            end
                        end
                        range_err_reg <= range_err_reg | (|lane_drop);
                        if (in_last) begin
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                            cnt_reg       <= '0;
                            out_last_reg  <= (RESULT_LEN == 1);
                            state_reg     <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (drain_fire) begin
                        if (out_last_reg) begin
                            cnt_reg       <= '0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                            state_reg     <= IDLE;
                        end else begin
                            cnt_reg      <= cnt_reg + IDX_W'(1);
                            // Registered look-ahead: the next index is the last one.
                            out_last_reg <= (cnt_reg == IDX_W'(RESULT_LEN - 2));
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_index = cnt_reg;
    // Buffer contents are only exposed while draining; zero otherwise.
    assign out_coeff = out_valid_reg ? acc_reg[cnt_reg] : '0;
    assign busy      = busy_reg;
    assign range_err = range_err_reg;

endmodule

// File: doc/polymult_result_accumulator.md
Name: polymult_result_accumulator

Overview:
- Sits directly downstream of the polynomial multiplier core.
- Consumes its per-tile partial-product beats (LANES coefficients of 2*DATA_WIDTH bits, plus a base coefficient index) and accumulates them into a full result-polynomial buffer of RESULT_LEN coefficients.
- After the multiplier signals its final beat, drains the finished polynomial one coefficient per cycle over a valid/ready stream to the next stage, e.g. modular reduction.

Parameters:
- DATA_WIDTH, 64, input operand coefficient width; products are 2*DATA_WIDTH.
- LANES, 8, coefficients per input beat; matches the multiplier tile width.
- POLY_A_WIDTH, 64, coefficients in polynomial A.
- POLY_B_WIDTH, 64, coefficients in polynomial B.
- GUARD_BITS, 8, extra accumulator bits above 2*DATA_WIDTH.
- RESULT_LEN, POLY_A_WIDTH+POLY_B_WIDTH-1 (127), derived; result coefficients.
- IDX_W, $clog2(RESULT_LEN) (7), derived.
- ACC_W, 2*DATA_WIDTH+GUARD_BITS (136), derived.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse in IDLE: clear buffer, begin a new product.
- in_valid  in  1  beat valid; driven by multiplier outputs_ready_signal.
- in_ready  out  1  accumulator accepts a beat.
- in_base  in  IDX_W  result index of lane 0 for this beat.
- in_coeffs  in  LANES*2*DATA_WIDTH  packed [LANES-1:0][2*DATA_WIDTH-1:0] partial products.
- in_last  in  1  final beat of the product; driven by multiplier done.
- out_valid  out  1  drained coefficient valid.
- out_ready  in  1  downstream accepts the coefficient.
- out_index  out  IDX_W  index of out_coeff.
- out_coeff  out  ACC_W  accumulated coefficient.
- out_last  out  1  high with index RESULT_LEN-1.
- busy  out  1  state != IDLE.
- range_err  out  1  sticky; set when a non-zero lane falls beyond RESULT_LEN-1.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all acc entries 0; drain counter 0; in_ready, out_valid, out_last, busy, range_err all 0; out_index 0; out_coeff 0.
- FSM states:
  - IDLE: in_ready=0, out_valid=0. start=1 → all acc entries cleared to 0 on that edge, range_err cleared, → ACCUM.
  - ACCUM: in_ready=1. On in_valid&&in_ready, for each lane k: if in_base+k < RESULT_LEN, acc[in_base+k] += zero-extend(in_coeffs[k]), computed modulo 2^ACC_W. Lanes with index >= RESULT_LEN are discarded; range_err sets if any discarded lane is non-zero. A beat with in_last=1 is accumulated and the state → DRAIN on the same edge.
  - DRAIN: in_ready=0; out_valid=1; out_index=cnt; out_coeff=acc[cnt]; out_last=(cnt==RESULT_LEN-1). On out_valid&&out_ready, cnt increments. After the handshake with out_last=1, cnt←0 and state → IDLE.
- Index arithmetic: in_base+k is computed at IDX_W+1 bits so the range check cannot alias.
- Latency: first drained coefficient valid the cycle after the in_last beat is accepted. A full drain takes RESULT_LEN cycles with out_ready held high.
- out_coeff and out_index stay stable while out_valid=1 and out_ready=0.
- start outside IDLE is ignored.
- in_valid outside ACCUM is ignored; no state change, no accumulation.
- in_last without in_valid has no effect.
- Overlapping lane indices across beats accumulate; order is irrelevant.
- Reset asserted mid-ACCUM or mid-DRAIN: immediate return to reset values; partial result lost.
- range_err holds its value through DRAIN and IDLE until the next start or reset.

Decomposition:
- polymult_pkg holds:
  - constants DATA_WIDTH, LANES, GUARD_BITS, RESULT_LEN, IDX_W, ACC_W.
  - typedef prod_t logic [2*DATA_WIDTH-1:0].
  - typedef acc_t logic [ACC_W-1:0].
  - typedef beat_t prod_t [LANES-1:0].
  - enum acc_state_e {IDLE, ACCUM, DRAIN}.
- One sub-module is natural: polymult_acc_lane_add. It is combinational per lane: index compute, range check, zero-extend, add-enable. Instantiated LANES times by generate. The FSM and buffer live in the top module.

Test Plan:
1. Reset then start; single beat in_base=0, coeffs k+1 (1..8), in_last=1 → drain acc[0..7]=1..8, acc[8..126]=0, out_last at index 126, then IDLE.
2. Two beats in_base=4, all lanes 10; second with in_last → acc[4..11]=20, others 0; range_err=0.
3. Beat in_base=124, lanes 0..2=5, lanes 3..7=0, in_last → acc[124..126]=5, range_err=0. Repeat with lane 3=1 → range_err=1, the lane-3 value is dropped, and range_err stays high through DRAIN.
4. Beat with in_base=0 and all lanes 2^128-1, repeated 256 times (last beat in_last) → acc[0..7]=(2^128-1)*256 mod 2^136, no truncation below ACC_W.
5. During DRAIN, toggle out_ready 1,0,0,1 → out_index/out_coeff hold while stalled; all 127 indices are emitted exactly once, in order.
6. Assert rst low mid-ACCUM after 3 beats → all outputs return to reset values immediately. Then start with a single beat in_base=0, lanes=7, in_last → acc[0..7]=7, with no residue from the aborted run.
